// File: rtl/sram_port_ctrl_if.sv
// sram_port_ctrl_if: client-side read/write request bus of sram_port_ctrl
interface sram_port_ctrl_if;
  logic rd_req;
  logic [19:0] rd_addr;
  logic rd_ack;
  logic rd_valid;
  logic [15:0] rd_data;
  logic wr_req;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic [1:0] wr_be;
  logic wr_ready;
  modport master(output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, input rd_ack, rd_valid, rd_data, wr_ready);
  modport slave(input rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, output rd_ack, rd_valid, rd_data, wr_ready);
endinterface

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: async SRAM port with read priority, posted write FIFO and fully registered pins
module sram_port_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int WFIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  sram_port_ctrl_if.slave bus,
  output logic busy,
  output logic [19:0] SRAM_ADDR,
  inout wire [15:0] SRAM_DQ,
  output logic SRAM_CE_N,
  output logic SRAM_OE_N,
  output logic SRAM_WE_N,
  output logic SRAM_UB_N,
  output logic SRAM_LB_N
);
  localparam int AW = $clog2(WFIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(WFIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
  state_t state, next;
  logic [19:0] f_addr [WFIFO_DEPTH];
  logic [15:0] f_data [WFIFO_DEPTH];
  logic [1:0] f_be [WFIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [2:0] cnt;
  logic [15:0] dq_out;
  logic dq_oe, push, grant_rd, grant_wr, start_wr, rd_last;
  assign bus.wr_ready = count != FULL;
  assign push = bus.wr_req && bus.wr_ready;
  assign grant_rd = state == IDLE && count != FULL && bus.rd_req;
  assign grant_wr = state == IDLE && !grant_rd && |count;
  assign start_wr = grant_wr && f_be[rd_ptr] != 2'b00;
  assign rd_last = state == RD && cnt == 3'd0;
  assign bus.rd_ack = grant_rd;
  assign busy = state != IDLE;
  assign SRAM_DQ = dq_oe ? dq_out : 16'bz;
  always_comb begin
    next = IDLE;
    case (state)
      IDLE: next = grant_rd ? RD : start_wr ? WR_SETUP : IDLE;
      RD: next = cnt == 3'd0 ? IDLE : RD;
      WR_SETUP: next = WR_PULSE;
      WR_PULSE: next = cnt == 3'd0 ? WR_HOLD : WR_PULSE;
      default: next = IDLE;
    endcase
  end
  // pins are loaded from next-state so they change on the same edge as the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      dq_oe <= 1'b0;
      dq_out <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_data <= '0;
    end else begin
      state <= next;
      cnt <= state == next ? cnt - 3'd1 : 3'(WAIT_CYCLES);
      count <= count + (AW+1)'(push) - (AW+1)'(grant_wr);
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(grant_wr);
      SRAM_ADDR <= grant_rd ? bus.rd_addr : start_wr ? f_addr[rd_ptr] : SRAM_ADDR;
      dq_out <= start_wr ? f_data[rd_ptr] : dq_out;
      dq_oe <= next == WR_SETUP || next == WR_PULSE || next == WR_HOLD;
      SRAM_CE_N <= next == IDLE;
      SRAM_OE_N <= next != RD;
      SRAM_WE_N <= next != WR_PULSE;
      SRAM_UB_N <= next == IDLE ? 1'b1 : grant_rd ? 1'b0 : start_wr ? ~f_be[rd_ptr][1] : SRAM_UB_N;
      SRAM_LB_N <= next == IDLE ? 1'b1 : grant_rd ? 1'b0 : start_wr ? ~f_be[rd_ptr][0] : SRAM_LB_N;
      bus.rd_valid <= rd_last;
      bus.rd_data <= rd_last ? SRAM_DQ : bus.rd_data;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      f_addr[wr_ptr] <= bus.wr_addr;
      f_data[wr_ptr] <= bus.wr_data;
      f_be[wr_ptr] <= bus.wr_be;
    end
  end
endmodule

// File: doc/sram_port_ctrl.md
SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra access cycles added to every read and write strobe (0..7).
REQ-002 Parameter WFIFO_DEPTH, default 4: number of posted write entries (power of two).
REQ-003 clk  input  1  single clock for all logic (50 MHz domain).
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 rd_req  input  1  read request; holds until acknowledged.
REQ-006 rd_addr  input  20  read word address.
REQ-007 rd_ack  output  1  one-cycle pulse when the read is granted.
REQ-008 rd_valid  output  1  one-cycle pulse when rd_data is valid.
REQ-009 rd_data  output  16  read word; holds its value until the next rd_valid.
REQ-010 wr_req  input  1  write push strobe.
REQ-011 wr_addr  input  20  write word address.
REQ-012 wr_data  input  16  write data.
REQ-013 wr_be  input  2  active-high byte enables; bit 1 is the upper byte, bit 0 the lower byte.
REQ-014 wr_ready  output  1  write FIFO not full.
REQ-015 busy  output  1  state is not IDLE.
REQ-016 SRAM_ADDR  output  20  external address.
REQ-017 SRAM_DQ  inout  16  external data; high-Z unless this block is writing.
REQ-018 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  active-low SRAM controls.

Function
REQ-019 All SRAM_* outputs and the SRAM_DQ output enable are registered.
- No combinational path from any input to any SRAM pin.

REQ-020 Write FIFO
- Push occurs on wr_req && wr_ready; each entry stores {addr, data, be}.
- wr_ready = (count < WFIFO_DEPTH), computed from the registered count.
- A push while full is ignored; pop in the same cycle does not unblock it.

REQ-021 States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.

REQ-022 IDLE arbitration
- FIFO full: a write is granted.
- Otherwise, rd_req asserted: the read is granted.
- Otherwise, FIFO not empty: a write is granted.
- Otherwise: stay in IDLE.

REQ-023 Read grant
- rd_ack is asserted in the grant cycle (combinational from state and arbitration).
- rd_addr is latched into SRAM_ADDR and the FSM enters RD.

REQ-024 RD
- Lasts WAIT_CYCLES+1 cycles with CE_N=0, OE_N=0, UB_N=0, LB_N=0, WE_N=1, DQ high-Z.
- SRAM_DQ is sampled at the clock edge that ends the last RD cycle.
- rd_data is updated and rd_valid pulses in the following cycle; the FSM returns to IDLE.

REQ-025 Read latency: grant cycle T produces rd_valid in cycle T+WAIT_CYCLES+2.

REQ-026 Write grant
- The FIFO head is popped, its fields latched, and the FSM enters WR_SETUP.

REQ-027 WR_SETUP (1 cycle)
- ADDR valid, CE_N=0, OE_N=1, WE_N=1.
- DQ driven with the entry data.
- UB_N = ~be[1], LB_N = ~be[0].

REQ-028 WR_PULSE: WE_N=0 for WAIT_CYCLES+1 cycles; ADDR, DQ, UB_N and LB_N unchanged.

REQ-029 WR_HOLD (1 cycle): WE_N=1, DQ still driven; then IDLE.

REQ-030 Byte enables: an entry with wr_be=2'b00 is still popped but performs no access (IDLE to IDLE, one cycle).

REQ-031 Back-to-back access: at least one IDLE cycle between accesses (CE_N=1 in IDLE); OE_N and WE_N are never low in the same cycle.

REQ-032 IDLE pins: CE_N, OE_N, WE_N, UB_N and LB_N all 1; DQ high-Z; SRAM_ADDR holds its last value.

Reset
REQ-033 Effect of reset on the next edge, in any state:
- state=IDLE, FIFO emptied (count=0).
- SRAM controls all 1, DQ high-Z, SRAM_ADDR=0.
- rd_valid=0, rd_data=0, busy=0.
- wr_ready=1 in the first cycle after reset.

REQ-034 Reset mid-read or mid-write aborts the access with no rd_valid; the lost write is not retried.

Verification (WAIT_CYCLES=1, SRAM model with mem[0x00010]=0xBEEF)
REQ-035 Read of 0x00010 granted at cycle T:
- rd_ack at T; OE_N=0 for T+1..T+2; rd_valid with rd_data=0xBEEF at T+3; DQ high-Z throughout.

REQ-036 Write {0x00020, 0x1234, be=2'b11} into an idle block:
- SETUP 1 cycle, WE_N=0 for 2 cycles, HOLD 1 cycle, DQ=0x1234 all 4 cycles.
- A subsequent read of 0x00020 returns 0x1234.

REQ-037 Five pushes with rd_req held high:
- wr_ready falls after the 4th push; the 5th is ignored.
- The first grant goes to the write (FIFO full), then the read, then the remaining writes.
- Memory holds exactly 4 new words.

REQ-038 Byte write {0x00010, 0xAA55, be=2'b01} to word 0xBEEF:
- UB_N=1, LB_N=0 during the write; a readback returns 0xBE55.

REQ-039 Reset asserted in the 2nd WR_PULSE cycle with 2 entries queued:
- Next cycle all controls are 1, DQ is high-Z, wr_ready=1, busy=0.
- No further SRAM accesses occur.

REQ-040 Simultaneous rd_req and wr_req with FIFO empty:
- Read granted first (rd_ack that cycle); the write starts in WR_SETUP after the IDLE cycle that follows rd_valid.
